// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared UART TX arbiter.
// The arbiter connects through the slave modport; the producer/transmitter side uses master.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] data_in;
  logic [NREQ-1:0]   lock;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [NREQ-1:0]   ack;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              err;

  modport master (
    output req, data_in, lock, tx_busy, tx_done,
    input  tx_start, tx_data, ack, grant_id, busy, err
  );

  modport slave (
    input  req, data_in, lock, tx_busy, tx_done,
    output tx_start, tx_data, ack, grant_id, busy, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, per-byte arbiter sharing one 8N1 UART transmitter among NREQ requesters.
// Optional macro UART_ARB_LOCK_EN: a locked winner keeps the link for consecutive bytes.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 8191
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [1:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [WDW-1:0] watchdog;

  logic [7:0]     bytes [NREQ];
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] cand;
  int             idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign bytes[g] = bus.data_in[8*g +: 8];
  end

  function automatic logic [NREQ-1:0] one_hot(input logic [IDW-1:0] i);
    one_hot    = '0;
    one_hot[i] = 1'b1;
  endfunction

  // Scan starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(rr_ptr) + k) % NREQ;
      cand = IDW'(idx);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // tx_start and ack are registered on the edge that enters LAUNCH, so they are
  // high for exactly the LAUNCH cycle and a reset edge suppresses them cleanly.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= IDW'(NREQ - 1);
      watchdog     <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
      bus.ack      <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      bus.ack      <= '0;
      case (state)
        IDLE: begin
          if (!bus.tx_busy && found) begin
            bus.tx_data  <= bytes[pick];
            bus.grant_id <= pick;
            rr_ptr       <= pick;
            bus.tx_start <= 1'b1;
            bus.ack      <= one_hot(pick);
            bus.busy     <= 1'b1;
            state        <= LAUNCH;
          end
        end

        LAUNCH: begin
          watchdog <= '0;
          state    <= WAIT_DONE;
        end

        WAIT_DONE: begin
          watchdog <= watchdog + 1'b1;
          if (bus.tx_done) begin
`ifdef UART_ARB_LOCK_EN
            if (bus.lock[bus.grant_id] && bus.req[bus.grant_id]) begin
              // Locked frame continues: same winner, rr_ptr untouched.
              bus.tx_data  <= bytes[bus.grant_id];
              bus.tx_start <= 1'b1;
              bus.ack      <= one_hot(bus.grant_id);
              state        <= LAUNCH;
            end else begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
`else
            bus.busy <= 1'b0;
            state    <= IDLE;
`endif
          end else if (watchdog == WDW'(TIMEOUT - 1)) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, round-robin order,
// tx_busy hold-off, watchdog timeout, mid-transfer reset and lock behaviour.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 8191;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   n_start;
  int   n_ack;

  uart_tx_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) n_start++;
    if (|bus.ack) n_ack++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_launch(input int budget, output int waited, output bit ok);
    waited = 0;
    while (bus.tx_start !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    ok = (bus.tx_start === 1'b1);
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({bus.tx_start, bus.tx_data, bus.ack, bus.grant_id, bus.busy, bus.err} !== 17'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got start=%b data=%h ack=%b gid=%0d busy=%b err=%b, want all zero",
               bus.tx_start, bus.tx_data, bus.ack, bus.grant_id, bus.busy, bus.err);
    end
  endtask

  task automatic test_single();
    bus.req     = 4'b0001;
    bus.data_in = 32'h0000_0055;
    tick();
    n_checks++;
    if ({bus.tx_start, bus.ack, bus.tx_data, bus.grant_id, bus.busy} !== {1'b1, 4'b0001, 8'h55, 2'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL single_launch: got start=%b ack=%b data=%h gid=%0d busy=%b, want 1 0001 55 0 1",
               bus.tx_start, bus.ack, bus.tx_data, bus.grant_id, bus.busy);
    end
    bus.req = 4'b0000;
    tick();
    n_checks++;
    if ({bus.tx_start, bus.ack, bus.busy} !== {1'b0, 4'b0000, 1'b1}) begin
      n_errors++;
      $display("FAIL single_wait: got start=%b ack=%b busy=%b, want 0 0000 1",
               bus.tx_start, bus.ack, bus.busy);
    end
    repeat (5) tick();
    pulse_done();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL single_done_busy: got busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_byte;
    logic [3:0] exp_ack;
    int waited;
    bit ok;
    int ack_before;
    apply_reset();
    bus.data_in = 32'hD3C2_B1A0;
    bus.req     = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      ack_before = n_ack;
      wait_launch(50, waited, ok);
      exp_byte = 8'hA0 + 8'h11 * 8'(exp_id[k]);
      exp_ack  = 4'b0001 << exp_id[k];
      n_checks++;
      if (!ok || bus.grant_id !== exp_id[k] || bus.ack !== exp_ack || bus.tx_data !== exp_byte) begin
        n_errors++;
        $display("FAIL rr_grant%0d: got ok=%b gid=%0d ack=%b data=%h, want gid=%0d ack=%b data=%h",
                 k, ok, bus.grant_id, bus.ack, bus.tx_data, exp_id[k], exp_ack, exp_byte);
      end
      if (k > 0) begin
        n_checks++;
        if (waited !== 1) begin
          n_errors++;
          $display("FAIL rr_latency%0d: got %0d cycles after done edge, want 1", k, waited);
        end
      end
      if (k == 4) bus.req = 4'b0000;
      repeat (19) tick();
      pulse_done();
      n_checks++;
      if (n_ack - ack_before !== 1) begin
        n_errors++;
        $display("FAIL rr_ack_count%0d: got %0d acks, want 1", k, n_ack - ack_before);
      end
    end
  endtask

  task automatic test_tx_busy();
    int start_before;
    bus.tx_busy  = 1'b1;
    bus.req      = 4'b0100;
    start_before = n_start;
    repeat (10) tick();
    n_checks++;
    if (n_start !== start_before || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_holdoff: got %0d starts busy=%b, want 0 starts busy=0",
               n_start - start_before, bus.busy);
    end
    bus.tx_busy = 1'b0;
    tick();
    n_checks++;
    if ({bus.tx_start, bus.grant_id, bus.ack, bus.tx_data} !== {1'b1, 2'd2, 4'b0100, 8'hC2}) begin
      n_errors++;
      $display("FAIL busy_release: got start=%b gid=%0d ack=%b data=%h, want 1 2 0100 c2",
               bus.tx_start, bus.grant_id, bus.ack, bus.tx_data);
    end
    bus.req = 4'b0000;
    repeat (10) tick();
    pulse_done();
  endtask

  task automatic test_timeout();
    int n;
    bus.req = 4'b0001;
    tick();
    n_checks++;
    if (bus.tx_start !== 1'b1 || bus.grant_id !== 2'd0) begin
      n_errors++;
      $display("FAIL to_launch: got start=%b gid=%0d, want 1 0", bus.tx_start, bus.grant_id);
    end
    bus.req = 4'b0000;
    tick();
    n = 0;
    while (bus.err !== 1'b1 && n < TIMEOUT + 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== TIMEOUT || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL to_cycles: got err after %0d cycles busy=%b, want %0d busy=0", n, bus.busy, TIMEOUT);
    end
    bus.req = 4'b0010;
    tick();
    n_checks++;
    if ({bus.tx_start, bus.grant_id, bus.err} !== {1'b1, 2'd1, 1'b1}) begin
      n_errors++;
      $display("FAIL to_next_serve: got start=%b gid=%0d err=%b, want 1 1 1",
               bus.tx_start, bus.grant_id, bus.err);
    end
    bus.req = 4'b0000;
    repeat (5) tick();
    pulse_done();
    n_checks++;
    if (bus.err !== 1'b1) begin
      n_errors++;
      $display("FAIL to_sticky: got err=%b, want 1", bus.err);
    end
  endtask

  task automatic test_reset_mid();
    int start_before;
    int ack_before;
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({bus.busy, bus.err, bus.tx_start, bus.ack, bus.grant_id} !== 9'd0) begin
      n_errors++;
      $display("FAIL mid_reset: got busy=%b err=%b start=%b ack=%b gid=%0d, want all zero",
               bus.busy, bus.err, bus.tx_start, bus.ack, bus.grant_id);
    end
    start_before = n_start;
    ack_before   = n_ack;
    pulse_done();
    repeat (5) tick();
    n_checks++;
    if (n_start !== start_before || n_ack !== ack_before || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_late_done: got %0d starts %0d acks busy=%b, want 0 0 0",
               n_start - start_before, n_ack - ack_before, bus.busy);
    end
  endtask

  task automatic test_lock();
`ifdef UART_ARB_LOCK_EN
    logic [1:0] exp_id [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
`else
    logic [1:0] exp_id [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
`endif
    logic [7:0] exp_byte;
    int waited;
    bit ok;
    apply_reset();
    bus.lock    = 4'b0010;
    bus.req     = 4'b0010;
    bus.data_in = {16'h0000, 8'h10, 8'h20};
    for (int k = 0; k < 4; k++) begin
      wait_launch(50, waited, ok);
      exp_byte = (exp_id[k] == 2'd1) ? 8'h10 + 8'(k) : 8'h20 + 8'(k);
      n_checks++;
      if (!ok || bus.grant_id !== exp_id[k] || bus.tx_data !== exp_byte) begin
        n_errors++;
        $display("FAIL lock_byte%0d: got ok=%b gid=%0d data=%h, want gid=%0d data=%h",
                 k, ok, bus.grant_id, bus.tx_data, exp_id[k], exp_byte);
      end
      bus.req     = (k == 3) ? 4'b0000 : 4'b0011;
      bus.data_in = {16'h0000, 8'h11 + 8'(k), 8'h21 + 8'(k)};
      repeat (19) tick();
      if (k == 2) bus.lock = 4'b0000;
      pulse_done();
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    bus.req      = '0;
    bus.data_in  = '0;
    bus.lock     = '0;
    bus.tx_busy  = 1'b0;
    bus.tx_done  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_tx_busy();
    test_timeout();
    test_reset_mid();
    test_lock();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
